// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down event counter family.
// Direction and bound-mode encodings match the up/sat input pins.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: tick asserts on every PRESCALE-th enabled cycle.
// Collapses to a wire (tick = en) when PRESCALE is 1.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  if (PRESCALE <= 1) begin : gen_bypass
    logic unused_ports;
    assign unused_ports = ^{clk, rst, sync_clr};
    assign tick         = en;
  end else begin : gen_count
    localparam int unsigned PsWidth = clog2(PRESCALE);
    localparam logic [PsWidth-1:0] PsLast = PsWidth'(PRESCALE - 1);

    logic [PsWidth-1:0] ps_q;
    logic [PsWidth-1:0] ps_d;
    logic               tick_c;

    always_comb begin
      tick_c = en && (ps_q == PsLast);
      ps_d   = ps_q;
      if (sync_clr) begin
        ps_d = '0;
      end else if (tick_c) begin
        ps_d = '0;
      end else if (en) begin
        ps_d = ps_q + PsWidth'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_d;
      end
    end

    assign tick = tick_c;
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter over 0..MAX_COUNT with clear, clamped load,
// prescaled stepping and a runtime wrap/saturate choice at the bounds.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic             at_bound,
  output logic             is_max,
  output logic             is_zero
);

  if ((WIDTH == 0) || ((WIDTH < 32) && ((MAX_COUNT >> WIDTH) != 0))) begin : gen_bad_width
    $error("param_updown_counter: MAX_COUNT must be < 2**WIDTH");
  end
  if (PRESCALE < 1) begin : gen_bad_prescale
    $error("param_updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             at_bound_q;
  logic             at_bound_d;
  logic             tick;
  logic             cnt_at_max;
  logic             cnt_at_zero;

  // Clear and load both restart the prescaler so the next step is a full period away.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign cnt_at_max  = (count_q == MaxVal);
  assign cnt_at_zero = (count_q == '0);

  always_comb begin
    count_d    = count_q;
    wrapped_d  = 1'b0;
    at_bound_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (tick) begin
      if (up == DIR_UP) begin
        if (!cnt_at_max) begin
          count_d = count_q + WIDTH'(1);
        end else if (sat == MODE_SAT) begin
          at_bound_d = 1'b1;
        end else begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (!cnt_at_zero) begin
          count_d = count_q - WIDTH'(1);
        end else if (sat == MODE_SAT) begin
          at_bound_d = 1'b1;
        end else begin
          count_d   = MaxVal;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      at_bound_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      at_bound_q <= at_bound_d;
    end
  end

  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign at_bound = at_bound_q;
  assign is_max   = cnt_at_max;
  assign is_zero  = cnt_at_zero;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter using three configurations that share
// one set of stimulus pins; each scenario checks only the instance it targets.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       sat = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] c9, c3, c99;
  logic       w9, ab9, mx9, z9;
  logic       w3, ab3, mx3, z3;
  logic       w99, ab99, mx99, z99;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(1)) u_dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .count(c9), .wrapped(w9), .at_bound(ab9), .is_max(mx9),
    .is_zero(z9)
  );

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .count(c3), .wrapped(w3), .at_bound(ab3), .is_max(mx3),
    .is_zero(z3)
  );

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(99), .PRESCALE(1)) u_dut99 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .count(c99), .wrapped(w99), .at_bound(ab99), .is_max(mx99),
    .is_zero(z99)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (c99 !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", c99); end
    n_cmp++; if (z99 !== 1'b1) begin n_err++; $display("FAIL rst_zero: got %b want 1", z99); end
    n_cmp++; if (mx99 !== 1'b0) begin n_err++; $display("FAIL rst_max: got %b want 0", mx99); end
    n_cmp++; if (w99 !== 1'b0 || ab99 !== 1'b0) begin
      n_err++; $display("FAIL rst_pulses: got %b%b want 00", w99, ab99);
    end
    #1 rst = 1'b1;
    // Load 37 then reset asynchronously between edges.
    load_val = 8'd37; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++; if (c99 !== 8'd37) begin n_err++; $display("FAIL load37: got %0d want 37", c99); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (c99 !== 8'd0) begin n_err++; $display("FAIL async_rst_count: got %0d want 0", c99); end
    n_cmp++; if (w99 !== 1'b0) begin n_err++; $display("FAIL async_rst_wrap: got %b want 0", w99); end
    n_cmp++; if (z99 !== 1'b1) begin n_err++; $display("FAIL async_rst_zero: got %b want 1", z99); end
    #2 rst = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_c;
    clr = 1'b1; en = 1'b0;
    step();
    clr = 1'b0; up = 1'b1; sat = 1'b0; en = 1'b1;
    exp_c = 8'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_c = (exp_c == 8'd9) ? 8'd0 : exp_c + 8'd1;
      n_cmp++; if (c9 !== exp_c) begin
        n_err++; $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, c9, exp_c);
      end
      n_cmp++; if (w9 !== (exp_c == 8'd0)) begin
        n_err++; $display("FAIL wrap_up_pulse[%0d]: got %b want %b", i, w9, exp_c == 8'd0);
      end
      if (exp_c == 8'd9) begin
        n_cmp++; if (mx9 !== 1'b1) begin n_err++; $display("FAIL wrap_up_ismax: got %b want 1", mx9); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_down();
    logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
    logic       exp_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    load_val = 8'd2; load = 1'b1; en = 1'b0;
    step();
    load = 1'b0; up = 1'b0; sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (c9 !== exp_c[i]) begin
        n_err++; $display("FAIL sat_down_count[%0d]: got %0d want %0d", i, c9, exp_c[i]);
      end
      n_cmp++; if (ab9 !== exp_b[i]) begin
        n_err++; $display("FAIL sat_down_bound[%0d]: got %b want %b", i, ab9, exp_b[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_up();
    load_val = 8'd9; load = 1'b1;
    step();
    load = 1'b0; up = 1'b1; sat = 1'b1; en = 1'b1;
    step();
    n_cmp++; if (c9 !== 8'd9 || ab9 !== 1'b1 || w9 !== 1'b0) begin
      n_err++; $display("FAIL sat_up_hold: got %0d/%b/%b want 9/1/0", c9, ab9, w9);
    end
    // Load edge suppresses the bound pulse even with a tick pending.
    load_val = 8'd4; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++; if (c9 !== 8'd4 || ab9 !== 1'b0) begin
      n_err++; $display("FAIL sat_up_load: got %0d/%b want 4/0", c9, ab9);
    end
    en = 1'b0;
  endtask

  task automatic test_prescale();
    logic       en_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp_c  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    clr = 1'b1; en = 1'b0;
    step();
    clr = 1'b0; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = en_seq[i];
      step();
      n_cmp++; if (c3 !== exp_c[i]) begin
        n_err++; $display("FAIL prescale_count[%0d]: got %0d want %0d", i, c3, exp_c[i]);
      end
    end
    en = 1'b0;
    // After reset the prescaler restarts: first step needs a full 3 enabled cycles.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    n_cmp++; if (c3 !== 8'd0) begin n_err++; $display("FAIL prescale_rst: got %0d want 0", c3); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (c3 !== ((i == 2) ? 8'd1 : 8'd0)) begin
        n_err++; $display("FAIL prescale_post_rst[%0d]: got %0d want %0d", i, c3, (i == 2) ? 1 : 0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    load_val = 8'd200; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++; if (c99 !== 8'd99) begin n_err++; $display("FAIL clamp_count: got %0d want 99", c99); end
    n_cmp++; if (mx99 !== 1'b1) begin n_err++; $display("FAIL clamp_ismax: got %b want 1", mx99); end
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd50;
    step();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    n_cmp++; if (c99 !== 8'd0 || z99 !== 1'b1) begin
      n_err++; $display("FAIL clr_over_load: got %0d/%b want 0/1", c99, z99);
    end
  endtask

  task automatic test_wrap_down();
    clr = 1'b1; en = 1'b0;
    step();
    clr = 1'b0; up = 1'b0; sat = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    n_cmp++; if (c9 !== 8'd9 || w9 !== 1'b1) begin
      n_err++; $display("FAIL wrap_down: got %0d/%b want 9/1", c9, w9);
    end
    // sat toggled on non-tick edges of the /3 instance must not matter.
    clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b1; sat = 1'b0;
    step();
    n_cmp++; if (c3 !== 8'd0 || ab3 !== 1'b0) begin
      n_err++; $display("FAIL sat_toggle_e1: got %0d/%b want 0/0", c3, ab3);
    end
    sat = 1'b1;
    step();
    n_cmp++; if (c3 !== 8'd0 || ab3 !== 1'b0) begin
      n_err++; $display("FAIL sat_toggle_e2: got %0d/%b want 0/0", c3, ab3);
    end
    sat = 1'b0;
    step();
    n_cmp++; if (c3 !== 8'd9 || w3 !== 1'b1 || ab3 !== 1'b0) begin
      n_err++; $display("FAIL sat_toggle_tick: got %0d/%b/%b want 9/1/0", c3, w3, ab3);
    end
    step();
    n_cmp++; if (c3 !== 8'd9 || w3 !== 1'b0) begin
      n_err++; $display("FAIL sat_toggle_after: got %0d/%b want 9/0", c3, w3);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_sat_up();
    test_prescale();
    test_load_clamp();
    test_wrap_down();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
